// File: rtl/branch_unit_if.sv
// Decode-to-branch-unit bundle: decoded branch request in, next-PC decision and stack status out.
interface branch_unit_if #(
  parameter int unsigned PC_COUNT_WIDTH = 6,
  parameter int unsigned STACK_DEPTH    = 4
);
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  logic                      instr_valid;
  logic [2:0]                branch_op;
  logic [PC_COUNT_WIDTH-1:0] branch_target;
  logic                      acc_zero;
  logic [PC_COUNT_WIDTH-1:0] pc_count;
  logic                      jump_enable;
  logic [PC_COUNT_WIDTH-1:0] jump_value;
  logic [SpW-1:0]            stack_count;
  logic                      stack_overflow;
  logic                      stack_underflow;

  modport master (
    output instr_valid, branch_op, branch_target, acc_zero, pc_count,
    input  jump_enable, jump_value, stack_count, stack_overflow, stack_underflow
  );

  modport slave (
    input  instr_valid, branch_op, branch_target, acc_zero, pc_count,
    output jump_enable, jump_value, stack_count, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/branch_unit.sv
// Next-PC decision stage: resolves JMP/JZ/JNZ/CALL/RET combinationally and keeps a
// return-address stack with sticky overflow/underflow flags.
module branch_unit #(
  parameter int unsigned PC_COUNT_WIDTH = 6,
  parameter int unsigned STACK_DEPTH    = 4
) (
  input logic           clk,
  input logic           reset,
  branch_unit_if.slave  bus
);
  localparam int unsigned SpW = $clog2(STACK_DEPTH + 1);

  typedef logic [PC_COUNT_WIDTH-1:0] pc_t;

  pc_t            stack_q [STACK_DEPTH];
  logic [SpW-1:0] sp_q;
  logic           overflow_q, underflow_q;

  logic           full, empty;
  logic [SpW-1:0] top_idx;
  pc_t            top_val;
  pc_t            ret_addr;
  logic           jump_enable;
  pc_t            jump_value;
  logic           push, pop, set_ovf, set_udf;

  assign full     = (sp_q == SpW'(STACK_DEPTH));
  assign empty    = (sp_q == '0);
  assign top_idx  = sp_q - 1'b1;
  assign ret_addr = bus.pc_count + 1'b1;

  // Explicit mux keeps the index width independent of the array bound.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (top_idx == SpW'(i)) top_val = stack_q[i];
    end
  end

  always_comb begin
    jump_enable = 1'b0;
    jump_value  = '0;
    push        = 1'b0;
    pop         = 1'b0;
    set_ovf     = 1'b0;
    set_udf     = 1'b0;
    if (reset && bus.instr_valid) begin
      case (bus.branch_op)
        3'b001: jump_enable = 1'b1;
        3'b010: jump_enable = bus.acc_zero;
        3'b011: jump_enable = ~bus.acc_zero;
        3'b100: begin
          jump_enable = ~full;
          push        = ~full;
          set_ovf     = full;
        end
        3'b101: begin
          jump_enable = ~empty;
          pop         = ~empty;
          set_udf     = empty;
        end
        default: jump_enable = 1'b0;
      endcase
      if (jump_enable) jump_value = pop ? top_val : bus.branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q        <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      if (push) begin
        for (int i = 0; i < int'(STACK_DEPTH); i++) begin
          if (sp_q == SpW'(i)) stack_q[i] <= ret_addr;
        end
        sp_q <= sp_q + 1'b1;
      end else if (pop) begin
        sp_q <= sp_q - 1'b1;
      end
      if (set_ovf) overflow_q  <= 1'b1;
      if (set_udf) underflow_q <= 1'b1;
    end
  end

  assign bus.jump_enable     = jump_enable;
  assign bus.jump_value      = jump_value;
  assign bus.stack_count     = sp_q;
  assign bus.stack_overflow  = overflow_q;
  assign bus.stack_underflow = underflow_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: decode cases, return stack LIFO order, full/empty, wrap, reset.
module tb_branch_unit;
  localparam int unsigned W = 6;
  localparam int unsigned D = 4;

  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpJmp  = 3'b001;
  localparam logic [2:0] OpJz   = 3'b010;
  localparam logic [2:0] OpJnz  = 3'b011;
  localparam logic [2:0] OpCall = 3'b100;
  localparam logic [2:0] OpRet  = 3'b101;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  branch_unit_if #(.PC_COUNT_WIDTH(W), .STACK_DEPTH(D)) bif ();

  branch_unit #(.PC_COUNT_WIDTH(W), .STACK_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] tgt,
                       input logic az, input logic [W-1:0] pc);
    bif.instr_valid   = v;
    bif.branch_op     = op;
    bif.branch_target = tgt;
    bif.acc_zero      = az;
    bif.pc_count      = pc;
    #1;
  endtask

  task automatic chk_jump(input string tag, input logic en, input logic [W-1:0] val);
    chk({tag, ".en"}, 32'(bif.jump_enable), 32'(en));
    chk({tag, ".val"}, 32'(bif.jump_value), 32'(val));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, OpJmp, 6'h2A, 1'b0, 6'h00);
    tick();
    tick();
    chk_jump("rst_forced", 1'b0, 6'h00);
    chk("rst_count", 32'(bif.stack_count), 0);

    // 1: basic jump out of reset
    reset = 1'b1;
    drive(1'b1, OpJmp, 6'h2A, 1'b0, 6'h00);
    chk_jump("jmp", 1'b1, 6'h2A);
    chk("jmp_ovf", 32'(bif.stack_overflow), 0);
    chk("jmp_udf", 32'(bif.stack_underflow), 0);
    chk("jmp_count", 32'(bif.stack_count), 0);

    // 2: conditional jumps, bubble and reserved ops
    drive(1'b1, OpJz, 6'h10, 1'b1, 6'h00);  chk_jump("jz_az1", 1'b1, 6'h10);
    drive(1'b1, OpJnz, 6'h10, 1'b1, 6'h00); chk_jump("jnz_az1", 1'b0, 6'h00);
    drive(1'b1, OpJz, 6'h10, 1'b0, 6'h00);  chk_jump("jz_az0", 1'b0, 6'h00);
    drive(1'b1, OpJnz, 6'h10, 1'b0, 6'h00); chk_jump("jnz_az0", 1'b1, 6'h10);
    drive(1'b0, OpJmp, 6'h15, 1'b0, 6'h00); chk_jump("bubble", 1'b0, 6'h00);
    drive(1'b1, 3'b110, 6'h15, 1'b0, 6'h00); chk_jump("op110", 1'b0, 6'h00);
    drive(1'b1, OpNone, 6'h15, 1'b0, 6'h00); chk_jump("none", 1'b0, 6'h00);
    drive(1'b0, OpCall, 6'h15, 1'b0, 6'h07);
    tick();
    chk("bubble_call_count", 32'(bif.stack_count), 0);

    // 3: nested call/return
    drive(1'b1, OpCall, 6'h20, 1'b0, 6'h05); chk_jump("call1", 1'b1, 6'h20);
    tick(); chk("call1_count", 32'(bif.stack_count), 1);
    drive(1'b1, OpCall, 6'h30, 1'b0, 6'h21); chk_jump("call2", 1'b1, 6'h30);
    tick(); chk("call2_count", 32'(bif.stack_count), 2);
    drive(1'b1, OpRet, 6'h00, 1'b0, 6'h30);  chk_jump("ret1", 1'b1, 6'h22);
    tick(); chk("ret1_count", 32'(bif.stack_count), 1);
    drive(1'b1, OpRet, 6'h00, 1'b0, 6'h23);  chk_jump("ret2", 1'b1, 6'h06);
    tick(); chk("ret2_count", 32'(bif.stack_count), 0);

    // 4: overflow on fifth call, then LIFO drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OpCall, 6'h08, 1'b0, 6'(6'h10 + i));
      chk_jump($sformatf("fill%0d", i), 1'b1, 6'h08);
      tick();
      chk($sformatf("fill%0d_count", i), 32'(bif.stack_count), 32'(i + 1));
    end
    drive(1'b1, OpCall, 6'h08, 1'b0, 6'h20); chk_jump("call_full", 1'b0, 6'h00);
    tick();
    chk("full_count", 32'(bif.stack_count), 4);
    chk("full_ovf", 32'(bif.stack_overflow), 1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, OpRet, 6'h00, 1'b0, 6'h00);
      chk_jump($sformatf("drain%0d", i), 1'b1, 6'(6'h14 - i));
      tick();
    end
    chk("drain_count", 32'(bif.stack_count), 0);
    chk("ovf_sticky", 32'(bif.stack_overflow), 1);

    // 5: underflow is sticky but does not block later ops
    drive(1'b1, OpRet, 6'h00, 1'b0, 6'h00); chk_jump("ret_empty", 1'b0, 6'h00);
    tick();
    chk("udf_set", 32'(bif.stack_underflow), 1);
    chk("udf_count", 32'(bif.stack_count), 0);
    drive(1'b1, OpJmp, 6'h01, 1'b0, 6'h00); chk_jump("jmp_after_udf", 1'b1, 6'h01);
    tick();
    chk("udf_sticky", 32'(bif.stack_underflow), 1);
    reset = 1'b0;
    drive(1'b1, OpNone, 6'h00, 1'b0, 6'h00);
    tick();
    chk("udf_cleared", 32'(bif.stack_underflow), 0);
    chk("ovf_cleared", 32'(bif.stack_overflow), 0);
    reset = 1'b1;

    // 6: return address wrap and reset overriding a call
    drive(1'b1, OpCall, 6'h00, 1'b0, 6'h3F); chk_jump("call_wrap", 1'b1, 6'h00);
    tick(); chk("wrap_count", 32'(bif.stack_count), 1);
    drive(1'b1, OpRet, 6'h00, 1'b0, 6'h00);  chk_jump("ret_wrap", 1'b1, 6'h00);
    tick(); chk("wrap_ret_count", 32'(bif.stack_count), 0);
    drive(1'b1, OpCall, 6'h05, 1'b0, 6'h07);
    tick(); chk("pre_rst_count", 32'(bif.stack_count), 1);
    reset = 1'b0;
    drive(1'b1, OpCall, 6'h09, 1'b0, 6'h0A); chk_jump("call_in_rst", 1'b0, 6'h00);
    tick();
    chk("rst_call_count", 32'(bif.stack_count), 0);
    chk("rst_call_ovf", 32'(bif.stack_overflow), 0);
    reset = 1'b1;
    drive(1'b1, OpRet, 6'h00, 1'b0, 6'h00); chk_jump("ret_after_rst", 1'b0, 6'h00);
    tick();
    chk("udf_after_rst", 32'(bif.stack_underflow), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
